uart_io: RTL and testbench

Memory-mapped UART peripheral that sits beside the data RAM on the single-cycle CPU's load/store bus and produces the `RxRdy`/`TxRdy` interrupt sources consumed by the CPU's IRQ and Cause logic. It serialises bytes written by the CPU onto `Tx` as 8N1 frames. It deserialises 8N1 frames arriving on `Rx` into a holding register. Status flags, overrun and framing errors are exposed for the bus decoder to map into the peripheral address space.

---
 rtl/uart_io.sv | 191 +++++++++++++++++++
 tb/tb_uart_io.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io.sv
`default_nettype none
// ============================================================================
// Module   : uart_io
// Function : memory-mapped 8N1 UART, independent TX/RX with sticky status flags
// Revision : 1.0
// ============================================================================
module uart_io #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       C,
  input  logic       R,
  input  logic       Rx,
  output logic       Tx,
  input  logic       TxWr,
  input  logic [7:0] TxIn,
  input  logic       TxAck,
  input  logic       RxRd,
  output logic [7:0] RxOut,
  output logic       TxBusy,
  output logic       TxRdy,
  output logic       RxRdy,
  output logic       RxOvr,
  output logic       RxFerr
);

  localparam logic [15:0] LAST_CNT = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_CNT = 16'(BAUD_DIV / 2);

  typedef enum logic [1:0] {TIDLE, TSTART, TDATA, TSTOP} tx_state_t;
  typedef enum logic [1:0] {RIDLE, RSTART, RDATA, RSTOP} rx_state_t;

  tx_state_t   tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_idx_q;
  logic [7:0]  tx_sh_q;
  logic        tx_q;
  logic        tx_rdy_q;

  rx_state_t   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_sh_q;
  logic [7:0]  rx_out_q;
  logic        rx_rdy_q;
  logic        rx_ovr_q;
  logic        rx_ferr_q;
  logic        rx_meta_q;
  logic        rxs_q;

  // Flag sets are written after clears so a same-cycle set wins.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      tx_state_q <= TIDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      tx_rdy_q   <= 1'b0;
    end else begin
      if (TxAck) tx_rdy_q <= 1'b0;
      case (tx_state_q)
        TIDLE: begin
          if (TxWr) begin
            tx_sh_q    <= TxIn;
            tx_q       <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= TSTART;
          end
        end
        TSTART: begin
          if (tx_cnt_q == LAST_CNT) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_q       <= tx_sh_q[0];
            tx_state_q <= TDATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        TDATA: begin
          if (tx_cnt_q == LAST_CNT) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TSTOP;
            end else begin
              tx_idx_q <= tx_idx_q + 3'd1;
              tx_q     <= tx_sh_q[1];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        TSTOP: begin
          if (tx_cnt_q == LAST_CNT) begin
            tx_cnt_q   <= '0;
            tx_rdy_q   <= 1'b1;
            tx_state_q <= TIDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: tx_state_q <= TIDLE;
      endcase
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Starting the count at half a bit puts every later sample mid-bit.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      rx_state_q <= RIDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_out_q   <= '0;
      rx_rdy_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      if (RxRd) begin
        rx_rdy_q <= 1'b0;
        rx_ovr_q <= 1'b0;
      end
      case (rx_state_q)
        RIDLE: begin
          if (!rxs_q) begin
            rx_cnt_q   <= HALF_CNT;
            rx_state_q <= RSTART;
          end
        end
        RSTART: begin
          if (rx_cnt_q == LAST_CNT) begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rxs_q ? RIDLE : RDATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RDATA: begin
          if (rx_cnt_q == LAST_CNT) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rxs_q, rx_sh_q[7:1]};
            rx_idx_q <= rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) rx_state_q <= RSTOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RSTOP: begin
          if (rx_cnt_q == LAST_CNT) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RIDLE;
            if (rxs_q) begin
              rx_out_q  <= rx_sh_q;
              rx_rdy_q  <= 1'b1;
              rx_ferr_q <= 1'b0;
              if (rx_rdy_q) rx_ovr_q <= 1'b1;
            end else begin
              rx_ferr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= RIDLE;
      endcase
    end
  end

  assign Tx     = tx_q;
  assign TxBusy = (tx_state_q != TIDLE);
  assign TxRdy  = tx_rdy_q;
  assign RxOut  = rx_out_q;
  assign RxRdy  = rx_rdy_q;
  assign RxOvr  = rx_ovr_q;
  assign RxFerr = rx_ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_io
// Function : scoreboard bench for uart_io with a frame-level reference model
// Revision : 1.0
// ============================================================================
module tb_uart_io;

  localparam int BD  = 16;
  localparam int PER = 10;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       w_rx;
  logic       TxWr = 1'b0;
  logic [7:0] TxIn = 8'h00;
  logic       TxAck = 1'b0;
  logic       RxRd = 1'b0;
  logic       Tx, TxBusy, TxRdy, RxRdy, RxOvr, RxFerr;
  logic [7:0] RxOut;

  int total = 0;
  int bad   = 0;

  assign w_rx = loop ? Tx : rx_drv;

  uart_io #(.BAUD_DIV(BD)) dut (
    .C(C), .R(R), .Rx(w_rx), .Tx(Tx), .TxWr(TxWr), .TxIn(TxIn), .TxAck(TxAck),
    .RxRd(RxRd), .RxOut(RxOut), .TxBusy(TxBusy), .TxRdy(TxRdy), .RxRdy(RxRdy),
    .RxOvr(RxOvr), .RxFerr(RxFerr)
  );

  always #5 C = ~C;

  typedef struct {
    longint     due;
    bit         has_pre;
    logic [7:0] pre_out;
    logic       pre_rdy;
    logic [7:0] out;
    logic       rdy;
    logic       ovr;
    logic       ferr;
  } rx_exp_t;

  rx_exp_t    rxq[$];
  logic [7:0] txq[$];
  rx_exp_t    mon_e;

  // Reference state: receive holding register/flags and transmitter occupancy.
  logic [7:0] m_out  = 8'h00;
  logic       m_rdy  = 1'b0;
  logic       m_ovr  = 1'b0;
  logic       m_ferr = 1'b0;
  bit         tx_have = 1'b0;
  longint     tx_last = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic rx_expect_frame(input logic [7:0] b, input bit stop, input bit rd_same,
                                 input longint due);
    rx_exp_t e;
    e.due     = due;
    e.has_pre = 1'b1;
    e.pre_out = m_out;
    e.pre_rdy = m_rdy;
    if (stop) begin
      m_ovr  = m_rdy ? 1'b1 : (rd_same ? 1'b0 : m_ovr);
      m_rdy  = 1'b1;
      m_out  = b;
      m_ferr = 1'b0;
    end else begin
      m_ferr = 1'b1;
      if (rd_same) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
    end
    e.out = m_out; e.rdy = m_rdy; e.ovr = m_ovr; e.ferr = m_ferr;
    rxq.push_back(e);
  endtask

  task automatic rx_expect_now(input longint due);
    rx_exp_t e;
    e.due = due; e.has_pre = 1'b0; e.pre_out = 8'h00; e.pre_rdy = 1'b0;
    e.out = m_out; e.rdy = m_rdy; e.ovr = m_ovr; e.ferr = m_ferr;
    rxq.push_back(e);
  endtask

  // Called at a negedge; first posedge to see the start bit is 5 ns later.
  task automatic rx_send(input logic [7:0] b, input bit stop);
    rx_expect_frame(b, stop, 1'b0, longint'($time) + 155 * PER);
    rx_drv = 1'b0;
    repeat (BD) @(negedge C);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BD) @(negedge C);
    end
    rx_drv = stop;
    repeat (BD) @(negedge C);
    rx_drv = 1'b1;
  endtask

  task automatic rx_read();
    RxRd = 1'b1;
    @(negedge C);
    RxRd = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    rx_expect_now(longint'($time));
  endtask

  // A write is taken only if the previous frame ended at least one edge earlier.
  task automatic tx_write(input logic [7:0] b, output bit acc, output longint t);
    TxWr = 1'b1;
    TxIn = b;
    @(posedge C);
    t   = longint'($time);
    acc = !tx_have || (t >= tx_last + 161 * PER);
    if (acc) begin
      tx_have = 1'b1;
      tx_last = t;
      txq.push_back(b);
    end
    @(negedge C);
    TxWr = 1'b0;
  endtask

  task automatic lb_send(input logic [7:0] b, input bit rd_same);
    bit     acc;
    longint t;
    tx_write(b, acc, t);
    if (acc) rx_expect_frame(b, 1'b1, rd_same, t + 155 * PER + 5);
    if (rd_same) begin
      repeat (154) @(negedge C);
      RxRd = 1'b1;
      @(negedge C);
      RxRd = 1'b0;
      repeat (5) @(negedge C);
    end else begin
      repeat (160) @(negedge C);
    end
  endtask

  logic rec [200];
  int   rec_n = 0;
  bit   recording = 1'b0;

  always @(negedge C) begin
    if (!R) begin
      recording = 1'b0;
      rec_n     = 0;
    end else if (TxBusy) begin
      if (rec_n < 200) rec[rec_n] = Tx;
      rec_n++;
      recording = 1'b1;
    end else if (recording) begin
      recording = 1'b0;
      if (txq.size() == 0) begin
        chk("tx_unexpected_frame", 32'd1, 32'd0);
      end else begin
        logic [7:0] b;
        logic [9:0] fr;
        int         errs;
        b    = txq.pop_front();
        fr   = {1'b1, b, 1'b0};
        errs = 0;
        for (int j = 0; j < 160; j++)
          if (rec[j] !== fr[j / BD]) errs++;
        chk($sformatf("tx_frame_%02h_len", b), rec_n, 160);
        chk($sformatf("tx_frame_%02h_bad_cycles", b), errs, 0);
        chk($sformatf("tx_frame_%02h_txrdy", b), TxRdy, 1'b1);
      end
      rec_n = 0;
    end
  end

  always @(negedge C) begin
    if (R && rxq.size() > 0) begin
      if (rxq[0].has_pre && longint'($time) == rxq[0].due - PER) begin
        chk("rx_early_rdy", RxRdy, rxq[0].pre_rdy);
        chk("rx_early_out", RxOut, rxq[0].pre_out);
      end
      if (longint'($time) >= rxq[0].due) begin
        mon_e = rxq.pop_front();
        chk("rx_out", RxOut, mon_e.out);
        chk("rx_rdy", RxRdy, mon_e.rdy);
        chk("rx_ovr", RxOvr, mon_e.ovr);
        chk("rx_ferr", RxFerr, mon_e.ferr);
      end
    end
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit     acc;
    longint t;

    repeat (3) @(negedge C);
    chk("rst_tx", Tx, 1'b1);
    chk("rst_txbusy", TxBusy, 1'b0);
    chk("rst_txrdy", TxRdy, 1'b0);
    chk("rst_rxrdy", RxRdy, 1'b0);
    chk("rst_rxovr", RxOvr, 1'b0);
    chk("rst_rxferr", RxFerr, 1'b0);
    chk("rst_rxout", RxOut, 8'h00);
    R = 1'b1;
    repeat (3) @(negedge C);

    // Transmit with a write attempt while busy and an acknowledge afterwards.
    tx_write(8'hA5, acc, t);
    repeat (39) @(negedge C);
    tx_write(8'hFF, acc, t);
    chk("tx_busy_mid", TxBusy, 1'b1);
    repeat (120) @(negedge C);
    chk("tx_rdy_after", TxRdy, 1'b1);
    chk("tx_busy_after", TxBusy, 1'b0);
    TxAck = 1'b1;
    @(negedge C);
    TxAck = 1'b0;
    chk("tx_ack_clears", TxRdy, 1'b0);

    rx_send(8'h5A, 1'b1);
    repeat (5) @(negedge C);
    rx_read();
    repeat (3) @(negedge C);

    rx_send(8'h11, 1'b0);
    repeat (15) @(negedge C);
    rx_send(8'h01, 1'b1);
    repeat (10) @(negedge C);
    rx_send(8'h02, 1'b1);
    repeat (10) @(negedge C);

    rx_drv = 1'b0;
    repeat (4) @(negedge C);
    rx_drv = 1'b1;
    repeat (200) @(negedge C);
    rx_expect_now(longint'($time));
    @(negedge C);
    rx_read();
    repeat (3) @(negedge C);

    loop = 1'b1;
    lb_send(8'h00, 1'b0);
    rx_read();
    lb_send(8'hFF, 1'b0);
    rx_read();
    lb_send(8'h81, 1'b1);
    repeat (3) @(negedge C);
    loop = 1'b0;
    repeat (5) @(negedge C);

    fork
      begin
        bit     a2;
        longint t2;
        for (int i = 0; i < 6; i++) begin
          repeat ($urandom_range(1, 220)) @(negedge C);
          tx_write(8'($urandom), a2, t2);
        end
        repeat (170) @(negedge C);
      end
      begin
        for (int k = 0; k < 8; k++) begin
          rx_send(8'($urandom), ($urandom_range(0, 3) != 0));
          repeat ($urandom_range(10, 30)) @(negedge C);
          if ($urandom_range(0, 1) == 1) rx_read();
        end
      end
    join

    rx_send(8'hC3, 1'b1);
    repeat (12) @(negedge C);

    // Asynchronous reset in the middle of a frame, checked before any clock edge.
    tx_write(8'hA5, acc, t);
    repeat (50) @(negedge C);
    #2 R = 1'b0;
    #1;
    chk("arst_tx", Tx, 1'b1);
    chk("arst_txbusy", TxBusy, 1'b0);
    chk("arst_txrdy", TxRdy, 1'b0);
    chk("arst_rxrdy", RxRdy, 1'b0);
    chk("arst_rxovr", RxOvr, 1'b0);
    chk("arst_rxferr", RxFerr, 1'b0);
    chk("arst_rxout", RxOut, 8'h00);
    txq.delete();
    rxq.delete();
    tx_have = 1'b0;
    m_out = 8'h00; m_rdy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (2) @(negedge C);
    R = 1'b1;
    repeat (2) @(negedge C);
    tx_write(8'h3C, acc, t);
    repeat (165) @(negedge C);

    for (int w = 0; w < 3000 && (txq.size() > 0 || rxq.size() > 0); w++) @(negedge C);
    chk("tx_pending", txq.size(), 0);
    chk("rx_pending", rxq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
